// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes and PC-source selects.
// Imported by the datapath registers and by the control unit.
package mcpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    PC_SRC_SEQ  = 2'd0,
    PC_SRC_BR   = 2'd1,
    PC_SRC_JMP  = 2'd2,
    PC_SRC_HOLD = 2'd3
  } pc_src_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mcpu_datapath_regs_if.sv
// Control strobes and data buses between the control unit / memory / register file
// and the multicycle datapath register block.
interface mcpu_datapath_regs_if #(parameter int ADDR_W = 8);

  logic              pc_write;
  logic              pc_write_cond;
  logic              iord;
  logic              ir_write;
  logic [1:0]        pc_source;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic [31:0]       mem_rdata;
  logic [31:0]       rf_rdata1;
  logic [31:0]       rf_rdata2;

  logic [31:0]       pc;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       ir;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [31:0]       imm_sext;
  logic [31:0]       imm_sext_sl2;
  logic [31:0]       mdr;
  logic [31:0]       reg_a;
  logic [31:0]       reg_b;
  logic [31:0]       alu_out;
  logic              branch_taken;

  modport master (
    output pc_write, pc_write_cond, iord, ir_write, pc_source, alu_result, alu_zero,
           mem_rdata, rf_rdata1, rf_rdata2,
    input  pc, mem_addr, ir, op, rs, rt, rd, funct, imm_sext, imm_sext_sl2, mdr,
           reg_a, reg_b, alu_out, branch_taken
  );

  modport slave (
    input  pc_write, pc_write_cond, iord, ir_write, pc_source, alu_result, alu_zero,
           mem_rdata, rf_rdata1, rf_rdata2,
    output pc, mem_addr, ir, op, rs, rt, rd, funct, imm_sext, imm_sext_sl2, mdr,
           reg_a, reg_b, alu_out, branch_taken
  );

endinterface

// File: rtl/mcpu_pc_next.sv
// Next-PC selection, beq/bne condition and PC load enable (purely combinational).
module mcpu_pc_next
  import mcpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_ir,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_alu_out,
  input  logic        i_alu_zero,
  input  logic [1:0]  i_pc_source,
  input  logic        i_pc_write,
  input  logic        i_pc_write_cond,
  output logic [31:0] o_pc_next,
  output logic        o_pc_load,
  output logic        o_branch_taken
);

  logic [31:0] w_sel;
  logic        w_cond;

  // Source mux; the low two bits are forced to zero so PC stays word aligned
  always_comb begin
    w_sel = i_pc;
    case (i_pc_source)
      PC_SRC_SEQ:  w_sel = i_alu_result;
      PC_SRC_BR:   w_sel = i_alu_out;
      PC_SRC_JMP:  w_sel = {i_pc[31:28], i_ir[25:0], 2'b00};
      PC_SRC_HOLD: w_sel = i_pc;
      default:     w_sel = i_pc;
    endcase
    o_pc_next = {w_sel[31:2], 2'b00};
  end

  // Branch condition from the opcode held in IR
  always_comb begin
    w_cond = 1'b0;
    case (i_ir[31:26])
      OP_BEQ:  w_cond = i_alu_zero;
      OP_BNE:  w_cond = ~i_alu_zero;
      default: w_cond = 1'b0;
    endcase
  end

  assign o_branch_taken = i_pc_write_cond & w_cond;
  assign o_pc_load      = i_pc_write | o_branch_taken;

endmodule

// File: rtl/mcpu_datapath_regs.sv
// Architectural and inter-cycle registers of the multicycle MIPS datapath
// (PC, IR, MDR, A, B, ALUOut) plus memory address mux and IR field decode.
module mcpu_datapath_regs
  import mcpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  mcpu_datapath_regs_if.slave bus
);

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] w_pc_next;
  logic        w_pc_load;

  mcpu_pc_next u_pc_next (
    .i_pc            (r_pc),
    .i_ir            (r_ir),
    .i_alu_result    (bus.alu_result),
    .i_alu_out       (r_alu_out),
    .i_alu_zero      (bus.alu_zero),
    .i_pc_source     (bus.pc_source),
    .i_pc_write      (bus.pc_write),
    .i_pc_write_cond (bus.pc_write_cond),
    .o_pc_next       (w_pc_next),
    .o_pc_load       (w_pc_load),
    .o_branch_taken  (bus.branch_taken)
  );

  // PC and IR: enabled loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_RESET;
      r_ir <= 32'h0000_0000;
    end else begin
      if (w_pc_load) r_pc <= w_pc_next;
      if (bus.ir_write) r_ir <= bus.mem_rdata;
    end
  end

  // Inter-cycle latches capture their sources on every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdr     <= 32'h0000_0000;
      r_a       <= 32'h0000_0000;
      r_b       <= 32'h0000_0000;
      r_alu_out <= 32'h0000_0000;
    end else begin
      r_mdr     <= bus.mem_rdata;
      r_a       <= bus.rf_rdata1;
      r_b       <= bus.rf_rdata2;
      r_alu_out <= bus.alu_result;
    end
  end

  assign bus.mem_addr     = bus.iord ? r_alu_out[ADDR_W+1:2] : r_pc[ADDR_W+1:2];
  assign bus.pc           = r_pc;
  assign bus.ir           = r_ir;
  assign bus.mdr          = r_mdr;
  assign bus.reg_a        = r_a;
  assign bus.reg_b        = r_b;
  assign bus.alu_out      = r_alu_out;
  assign bus.op           = r_ir[31:26];
  assign bus.rs           = r_ir[25:21];
  assign bus.rt           = r_ir[20:16];
  assign bus.rd           = r_ir[15:11];
  assign bus.funct        = r_ir[5:0];
  assign bus.imm_sext     = sext16(r_ir[15:0]);
  assign bus.imm_sext_sl2 = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

endmodule
